// File: rtl/cpu_pc_stack.sv
// Program-counter / return-address stack: circular DEPTH x ADDR_W array whose
// active entry is the fetch PC; CALL/RET move the pointer, JMP/INC rewrite it.
module cpu_pc_stack #(
  parameter  int ADDR_W = 14,
  parameter  int DEPTH  = 8,
  localparam int NDX_W  = $clog2(DEPTH)
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STALL_I,
  input  logic              INC_I,
  input  logic              JMP_I,
  input  logic              CALL_I,
  input  logic              RET_I,
  input  logic [ADDR_W-1:0] TGT_I,
  input  logic [ADDR_W-1:0] LINK_I,
  input  logic              CLR_I,
  output logic [ADDR_W-1:0] PC_O,
  output logic [NDX_W-1:0]  LEVEL_O,
  output logic              FLUSH_O,
  output logic              OVF_O,
  output logic              UDF_O
);

  localparam logic [NDX_W-1:0] LVL_MAX = NDX_W'(DEPTH - 1);

  logic [DEPTH-1:0][ADDR_W-1:0] stack;
  logic [NDX_W-1:0]             ndx;
  logic [NDX_W-1:0]             level;
  logic                         flush;
  logic                         ovf;
  logic                         udf;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      stack <= '0;
      ndx   <= '0;
      level <= '0;
      flush <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      flush <= 1'b0;
      // Clear first so a same-cycle overflow/underflow set below wins.
      if (CLR_I) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end
      if (!STALL_I) begin
        if (RET_I) begin
          ndx   <= ndx - 1'b1;
          flush <= 1'b1;
          if (level != '0) level <= level - 1'b1;
          else             udf   <= 1'b1;
        end else if (CALL_I) begin
          stack[ndx]        <= LINK_I;
          stack[ndx + 1'b1] <= TGT_I;
          ndx   <= ndx + 1'b1;
          flush <= 1'b1;
          // At full occupancy the pointer still advances, overwriting the oldest link.
          if (level != LVL_MAX) level <= level + 1'b1;
          else                  ovf   <= 1'b1;
        end else if (JMP_I) begin
          stack[ndx] <= TGT_I;
          flush      <= 1'b1;
        end else if (INC_I) begin
          stack[ndx] <= stack[ndx] + 1'b1;
        end
      end
    end
  end

  assign PC_O    = stack[ndx];
  assign LEVEL_O = level;
  assign FLUSH_O = flush;
  assign OVF_O   = ovf;
  assign UDF_O   = udf;

endmodule

// File: doc/cpu_pc_stack.md
Name: cpu_pc_stack

Overview:
- Parametrised program-counter / return-address stack for the pipelined 8008-class CPU.
- Replaces the fixed 8 x 14-bit circular address stack embedded in the core.
- Adds JMP, CALL and RET with registered redirect, occupancy tracking, sticky overflow/underflow flags, stall, and a one-cycle flush pulse that tells the fetch stages (F1-F3) to discard in-flight bytes.
- Sits between decode/execute (commands and targets) and the instruction ROM (address output).

Parameters:
- ADDR_W, 14, width of the instruction address, each stack entry and the PC.
- DEPTH, 8, number of stack entries including the active PC entry; must be a power of 2, minimum 2.
- NDX_W, log2(DEPTH), pointer width; derived, not to be overridden.

Ports:
- CLK_I  in  1  clock, all state changes on rising edge.
- RST_I  in  1  reset, asynchronous, active-high.
- STALL_I  in  1  hold all state; highest priority.
- INC_I  in  1  advance PC by 1.
- JMP_I  in  1  load TGT_I into PC.
- CALL_I  in  1  save LINK_I, push, load TGT_I.
- RET_I  in  1  pop; the saved link becomes PC.
- TGT_I  in  ADDR_W  jump/call target.
- LINK_I  in  ADDR_W  return address saved on CALL (address after the 3-byte instruction).
- CLR_I  in  1  clear sticky flags.
- PC_O  out  ADDR_W  current fetch address (stack[ndx]); drives I_ADDR_O.
- LEVEL_O  out  NDX_W  number of saved return addresses, 0..DEPTH-1.
- FLUSH_O  out  1  one-cycle pulse after an accepted redirect.
- OVF_O  out  1  sticky: CALL overwrote the oldest entry.
- UDF_O  out  1  sticky: RET with LEVEL_O=0.

Behaviour:
- Reset (asynchronous, whenever RST_I=1): all entries 0, ndx=0, LEVEL_O=0, PC_O=0, FLUSH_O=0, OVF_O=0, UDF_O=0. Deassertion is synchronous to the first edge after release; no command is accepted while RST_I=1. Reset mid-CALL or mid-RET leaves no partial update.
- PC_O is a direct read of stack[ndx]. Latency: an update at edge N is visible on PC_O after edge N.
- Command priority per cycle: STALL_I > RET_I > CALL_I > JMP_I > INC_I. Exactly one command (or none) is accepted; all lower-priority commands are ignored.
- STALL_I=1: no state change. FLUSH_O drops to 0. Flags still clear on CLR_I.
- INC: stack[ndx] <= stack[ndx]+1 mod 2^ADDR_W, so all-ones wraps to 0.
- JMP: stack[ndx] <= TGT_I.
- CALL: stack[ndx] <= LINK_I; stack[ndx+1 mod DEPTH] <= TGT_I; ndx <= ndx+1 mod DEPTH.
  - If LEVEL_O < DEPTH-1: LEVEL_O increments.
  - Else: LEVEL_O holds at DEPTH-1, OVF_O <= 1, and the oldest link is lost (circular overwrite).
- RET: ndx <= ndx-1 mod DEPTH; the entry at the new ndx is used unmodified as PC.
  - If LEVEL_O > 0: LEVEL_O decrements.
  - Else: LEVEL_O stays 0, UDF_O <= 1, and PC becomes the stale wrapped entry (8008-compatible).
- FLUSH_O <= 1 for exactly the cycle after any accepted JMP, CALL or RET, otherwise 0. Back-to-back redirects give consecutive pulses.
- CLR_I clears OVF_O/UDF_O at the edge. If a new overflow or underflow occurs in the same cycle, the set wins.
- No command asserted and no stall: state holds (idle, not INC).

Test Plan:
- Reset with PC at 0x0123: assert RST_I asynchronously between edges -> PC_O=0, LEVEL_O=0 and all flags 0 immediately, before the next edge.
- INC x3 from reset, then JMP TGT=0x3FFF, then INC -> PC_O 1,2,3,0x3FFF,0x0000; FLUSH_O high only the cycle after JMP.
- CALL TGT=0x0200 LINK=0x0013, CALL TGT=0x0300 LINK=0x0203, RET, RET -> PC_O 0x0200, 0x0300, 0x0203, 0x0013; LEVEL_O 1,2,1,0; no flags.
- 8 consecutive CALLs (DEPTH=8) -> LEVEL_O saturates at 7 and OVF_O sets on the 8th; then 7 RETs return the links of calls 8..2 in order.
- RET at LEVEL_O=0 -> UDF_O=1, LEVEL_O=0, PC_O=stack[7]. Then CLR_I with no command -> UDF_O=0. CLR_I together with another underflowing RET -> UDF_O stays 1.
- STALL_I=1 with CALL_I=1 and INC_I=1 -> no change and FLUSH_O=0. Drop the stall with RET_I=1 and CALL_I=1 -> RET wins; LEVEL_O decrements.
